// File: rtl/datapath_pkg.sv
// datapath_pkg: encodings shared by the datapath and its microcoded controller
package datapath_pkg;
  localparam int DW = 16;
  typedef enum logic [2:0] {
    FN_PASS = 3'b000,
    FN_ADD  = 3'b001,
    FN_SUB  = 3'b010,
    FN_AND  = 3'b011,
    FN_OR   = 3'b100,
    FN_XOR  = 3'b101,
    FN_NOT  = 3'b110,
    FN_INC  = 3'b111
  } fn_e;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
endpackage

// File: rtl/alu16.sv
// alu16: combinational ALU computing Z = f(Y, B) with {Z,N,C,V} flags
module alu16 import datapath_pkg::*; #(
  parameter int W = DW
) (
  input  logic [W-1:0] y,
  input  logic [W-1:0] b,
  input  logic [2:0]   funsel,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  logic [W:0] add, sub, inc;
  logic c, v;
  // result and flags; C is borrow for subtract, V only for arithmetic ops
  always_comb begin
    add = {1'b0, y} + {1'b0, b};
    sub = {1'b0, y} - {1'b0, b};
    inc = {1'b0, b} + {{W{1'b0}}, 1'b1};
    result = b;
    c = 1'b0;
    v = 1'b0;
    case (funsel)
      FN_ADD: begin
        result = add[W-1:0];
        c = add[W];
        v = (y[W-1] == b[W-1]) && (result[W-1] != y[W-1]);
      end
      FN_SUB: begin
        result = sub[W-1:0];
        c = sub[W];
        v = (y[W-1] != b[W-1]) && (result[W-1] != y[W-1]);
      end
      FN_AND: result = y & b;
      FN_OR:  result = y | b;
      FN_XOR: result = y ^ b;
      FN_NOT: result = ~b;
      FN_INC: begin
        result = inc[W-1:0];
        c = inc[W];
        v = !b[W-1] && result[W-1];
      end
      default: result = b;
    endcase
    flags = {result == '0, result[W-1], c, v};
  end
endmodule

// File: rtl/datapath_unit.sv
// datapath_unit: single-bus 16-bit datapath driven by the microcoded controller
module datapath_unit import datapath_pkg::*; #(
  parameter int DW = 16,
  parameter int NREG = 8,
  parameter logic [DW-1:0] PC_INIT = 16'h0000,
  parameter logic [DW-1:0] SP_INIT = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    funsel,
  input  logic          lsp,
  input  logic          lpc,
  input  logic          lmdr,
  input  logic          lmar,
  input  logic          lisr,
  input  logic          ly,
  input  logic          wrr,
  input  logic          mrw,
  input  logic [2:0]    rsel,
  input  logic          spmar,
  input  logic          pcmar,
  input  logic          mdrz,
  input  logic          mdrm,
  input  logic          tr,
  input  logic          tsp,
  input  logic          tpc,
  input  logic          tmdr,
  input  logic          tisr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic [DW-1:0] isr,
  output logic [3:0]    sreg,
  output logic          bus_err,
  output logic [DW-1:0] dbg_bus
);
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] pc, sp, mar, mdr, y, bus, z;
  logic [3:0] flg;
  logic [2:0] ndrv;
  logic set_flags;
  // prioritised bus mux; contention is detected from the raw driver count
  always_comb begin
    bus = tr ? regs[rsel] : tsp ? sp : tpc ? pc : tmdr ? mdr :
          tisr ? {{(DW-8){isr[7]}}, isr[7:0]} : '0;
    ndrv = {2'b0, tr} + {2'b0, tsp} + {2'b0, tpc} + {2'b0, tmdr} + {2'b0, tisr};
    set_flags = (funsel != FN_PASS) && (wrr || lsp || lpc || ly || (lmdr && mdrz));
  end
  alu16 #(.W(DW)) u_alu (
    .y(y),
    .b(bus),
    .funsel(funsel),
    .result(z),
    .flags(flg)
  );
  // all architectural state; reads use pre-edge values so tpc+lpc increments once
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= PC_INIT;
      sp <= SP_INIT;
      mar <= '0;
      mdr <= '0;
      isr <= '0;
      y <= '0;
      sreg <= '0;
      bus_err <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wrr) regs[rsel] <= z;
      if (lsp) sp <= z;
      if (lpc) pc <= z;
      if (ly) y <= bus;
      if (lmar) mar <= spmar ? sp : pcmar ? pc : z;
      if (lmdr && (mdrm || mdrz)) mdr <= mdrm ? mem_rdata : z;
      if (lisr) isr <= mdr;
      if (set_flags) sreg <= flg;
      if (ndrv > 3'd1) bus_err <= 1'b1;
    end
  assign mem_addr = mar;
  assign mem_wdata = mdr;
  assign mem_we = mrw;
  assign dbg_bus = bus;
endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: scoreboard bench for the datapath with a behavioural memory
module tb_datapath_unit;
  localparam int K_PC = 0, K_SP = 1, K_MAR = 2, K_MDR = 3, K_ISR = 4, K_SREG = 5, K_ERR = 6, K_R0 = 8;
  typedef struct {
    string tag;
    int kind;
    logic [15:0] exp;
  } exp_t;
  logic clk, reset;
  logic [2:0] funsel, rsel;
  logic lsp, lpc, lmdr, lmar, lisr, ly, wrr, mrw, spmar, pcmar, mdrz, mdrm;
  logic tr, tsp, tpc, tmdr, tisr;
  logic [15:0] mem_rdata, mem_addr, mem_wdata, isr, dbg_bus;
  logic mem_we, bus_err;
  logic [3:0] sreg;
  logic [15:0] mem [65536];
  logic ld_en;
  logic [15:0] ld_addr, ld_data;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;

  datapath_unit dut (
    .clk(clk), .reset(reset), .funsel(funsel),
    .lsp(lsp), .lpc(lpc), .lmdr(lmdr), .lmar(lmar), .lisr(lisr), .ly(ly), .wrr(wrr),
    .mrw(mrw), .rsel(rsel), .spmar(spmar), .pcmar(pcmar), .mdrz(mdrz), .mdrm(mdrm),
    .tr(tr), .tsp(tsp), .tpc(tpc), .tmdr(tmdr), .tisr(tisr),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .isr(isr), .sreg(sreg), .bus_err(bus_err), .dbg_bus(dbg_bus)
  );

  initial clk = 0;
  always #10 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic expect_(input string tag, input int kind, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.kind = kind;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic idle;
    {lsp, lpc, lmdr, lmar, lisr, ly, wrr, mrw, spmar, pcmar, mdrz, mdrm} = '0;
    {tr, tsp, tpc, tmdr, tisr} = '0;
    funsel = 3'd0;
    rsel = 3'd0;
  endtask

  task automatic observe(input int k, output logic [15:0] v);
    case (k)
      K_PC:   begin tpc = 1; #1; v = dbg_bus; tpc = 0; end
      K_SP:   begin tsp = 1; #1; v = dbg_bus; tsp = 0; end
      K_MAR:  begin #1; v = mem_addr; end
      K_MDR:  begin #1; v = mem_wdata; end
      K_ISR:  begin #1; v = isr; end
      K_SREG: begin #1; v = {12'b0, sreg}; end
      K_ERR:  begin #1; v = {15'b0, bus_err}; end
      default: begin rsel = 3'(k - K_R0); tr = 1; #1; v = dbg_bus; tr = 0; rsel = 0; end
    endcase
  endtask

  task automatic drain;
    exp_t e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, got);
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    idle;
    drain;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en = 1;
    @(posedge clk);
    #1;
    ld_en = 0;
  endtask

  task automatic mdr_load(input logic [15:0] v);
    poke(mem_addr, v);
    mdrm = 1;
    lmdr = 1;
    tick;
  endtask

  task automatic reset_values(input string p);
    expect_({p, "_pc"}, K_PC, 16'h0000);
    expect_({p, "_sp"}, K_SP, 16'hFFFF);
    expect_({p, "_mar"}, K_MAR, 16'h0000);
    expect_({p, "_mdr"}, K_MDR, 16'h0000);
    expect_({p, "_isr"}, K_ISR, 16'h0000);
    expect_({p, "_sreg"}, K_SREG, 16'h0000);
    expect_({p, "_err"}, K_ERR, 16'h0000);
    expect_({p, "_r2"}, K_R0 + 2, 16'h0000);
    drain;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ld_en = 0;
    ld_addr = 0;
    ld_data = 0;
    idle;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    reset_values("rst");
    chk("bus_idle", dbg_bus, 16'h0000);
    poke(16'h0000, 16'hC200);
    pcmar = 1; lmar = 1;
    expect_("fetch_mar", K_MAR, 16'h0000);
    tick;
    mdrm = 1; lmdr = 1;
    expect_("fetch_mdr", K_MDR, 16'hC200);
    tick;
    lisr = 1;
    expect_("fetch_isr", K_ISR, 16'hC200);
    tick;
    tpc = 1; lpc = 1; funsel = 3'd7;
    expect_("pc_inc", K_PC, 16'h0001);
    expect_("pc_inc_sreg", K_SREG, 16'h0000);
    tick;
    pcmar = 1; lmar = 1;
    expect_("mar_pc1", K_MAR, 16'h0001);
    tick;
    mdr_load(16'h0005);
    lisr = 1;
    tick;
    tisr = 1; ly = 1;
    expect_("ly_no_flags", K_SREG, 16'h0000);
    tick;
    mdr_load(16'h00FB);
    lisr = 1;
    tick;
    tisr = 1; funsel = 3'd1; wrr = 1; rsel = 3'd2;
    expect_("add_r2", K_R0 + 2, 16'h0000);
    expect_("add_zc", K_SREG, 16'h000A);
    tick;
    mdr_load(16'h7FFF);
    tmdr = 1; ly = 1;
    tick;
    mdr_load(16'h0001);
    tmdr = 1; funsel = 3'd1; lsp = 1;
    expect_("add_sp", K_SP, 16'h8000);
    expect_("add_nv", K_SREG, 16'h0005);
    tick;
    ly = 1;
    tick;
    tmdr = 1; funsel = 3'd2; lsp = 1;
    expect_("sub_sp", K_SP, 16'hFFFF);
    expect_("sub_nc", K_SREG, 16'h0006);
    tick;
    mdr_load(16'h1234);
    poke(16'hFFFF, 16'h0000);
    spmar = 1; lmar = 1;
    expect_("push_mar", K_MAR, 16'hFFFF);
    tick;
    mrw = 1; mdrm = 1; lmdr = 1;
    #1;
    chk("push_addr", mem_addr, 16'hFFFF);
    chk("push_we", {15'b0, mem_we}, 16'h0001);
    chk("push_wdata", mem_wdata, 16'h1234);
    expect_("push_old_read", K_MDR, 16'h0000);
    tick;
    chk("push_we_off", {15'b0, mem_we}, 16'h0000);
    mdrm = 1; lmdr = 1;
    expect_("pop_mdr", K_MDR, 16'h1234);
    tick;
    rsel = 3'd2; tr = 1; tpc = 1;
    #1;
    chk("contend_bus", dbg_bus, 16'h0000);
    expect_("contend_err", K_ERR, 16'h0001);
    tick;
    expect_("err_sticky", K_ERR, 16'h0001);
    tick;
    reset = 1;
    #1;
    reset_values("arst");
    @(posedge clk);
    #1;
    reset_values("hold");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
